// File: rtl/vector_divider_pkg.sv
// Shared types and default widths for the in-place vector divider.
package vector_divider_pkg;

  localparam int unsigned RamSizeDefault = 10;
  localparam int unsigned NDefault       = 5;
  localparam int unsigned NbitsDefault   = 32;

  // Controller states; DIV is the only multi-cycle state.
  typedef enum logic [3:0] {
    StIdle,
    StCheck,
    StRdA,
    StRdB,
    StLdB,
    StDiv,
    StWrQ,
    StWrR,
    StDone
  } state_e;

endpackage

// File: rtl/vector_divider_seq_divider.sv
// Serial unsigned restoring divider, one quotient bit per cycle.
// The first iteration is folded into the start cycle so the result is final
// after NBITS clock edges counted from the start edge; done then stays high
// until the next start. Divide by zero yields all-ones quotient, remainder = A.
module seq_divider #(
  parameter int unsigned N     = 5,
  parameter int unsigned NBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             done,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder
);

  localparam logic [N-1:0] CntOne = 1;

  logic [NBITS-1:0] rem_q, quo_q, div_q;
  logic [N-1:0]     cnt_q;
  logic             running_q, done_q;

  logic [NBITS-1:0] rem_src, quo_src, div_src;
  logic [NBITS:0]   shifted;
  logic             fits;
  logic [NBITS-1:0] rem_step, quo_step;

  // One restoring step; on start it operates directly on the new operands.
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    quo_src  = start ? dividend : quo_q;
    div_src  = start ? divisor : div_q;
    shifted  = {rem_src, quo_src[NBITS-1]};
    fits     = (shifted >= {1'b0, div_src});
    // When fits, the true difference is below div_src, so NBITS bits suffice.
    rem_step = fits ? (shifted[NBITS-1:0] - div_src) : shifted[NBITS-1:0];
    quo_step = {quo_src[NBITS-2:0], fits};
  end

  // Iteration state and completion flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      rem_q     <= rem_step;
      quo_q     <= quo_step;
      div_q     <= divisor;
      cnt_q     <= CntOne;
      running_q <= 1'b1;
      done_q    <= 1'b0;
    end else if (running_q) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q + CntOne;
      // cnt_q counts completed iterations; all-ones means the last one now.
      if (cnt_q == '1) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/vector_divider.sv
// Sequential in-place vector divider: for k < Ndata, reads the pair at
// (2k, 2k+1) through RAM port 2 and writes back quotient and remainder.
module vector_divider
  import vector_divider_pkg::*;
#(
  parameter int unsigned RAM_SIZE = RamSizeDefault,
  parameter int unsigned N        = NDefault,
  parameter int unsigned NBITS    = NbitsDefault
) (
  input  logic                clock,
  input  logic                reset,
  output logic [RAM_SIZE-1:0] Addr,
  output logic [NBITS-1:0]    Wdata,
  input  logic [NBITS-1:0]    Rdata,
  input  logic [RAM_SIZE-1:0] Ndata,
  output logic                Wenable,
  input  logic                startvd,
  output logic                busyvd
);

  localparam logic [RAM_SIZE-1:0] KOne = 1;

  state_e              state_q;
  logic [RAM_SIZE-1:0] k_q, ndata_q;
  logic [NBITS-1:0]    dividend_q;

  logic                div_start, div_done;
  logic [NBITS-1:0]    quotient, remainder;
  logic [RAM_SIZE-1:0] addr_even, addr_odd;

  // Pair addresses wrap modulo 2^RAM_SIZE by dropping the top bit of k.
  assign addr_even = {k_q[RAM_SIZE-2:0], 1'b0};
  assign addr_odd  = {k_q[RAM_SIZE-2:0], 1'b1};

  // Divisor is taken straight from Rdata in LD_B, when it holds M[2k+1].
  assign div_start = (state_q == StLdB);

  seq_divider #(
    .N     (N),
    .NBITS (NBITS)
  ) u_seq_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (dividend_q),
    .divisor   (Rdata),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Controller FSM; RAM-facing outputs are registered and set on entry to
  // the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      busyvd     <= 1'b0;
      Wenable    <= 1'b0;
      Addr       <= '0;
      Wdata      <= '0;
      k_q        <= '0;
      ndata_q    <= '0;
      dividend_q <= '0;
    end else begin
      Wenable <= 1'b0;
      case (state_q)
        StIdle: begin
          if (startvd) begin
            ndata_q <= Ndata;
            k_q     <= '0;
            busyvd  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (k_q == ndata_q) begin
            state_q <= StDone;
          end else begin
            Addr    <= addr_even;
            state_q <= StRdA;
          end
        end
        StRdA: begin
          Addr    <= addr_odd;
          state_q <= StRdB;
        end
        StRdB: begin
          dividend_q <= Rdata;
          state_q    <= StLdB;
        end
        StLdB: state_q <= StDiv;
        StDiv: begin
          if (div_done) begin
            Addr    <= addr_even;
            Wdata   <= quotient;
            Wenable <= 1'b1;
            state_q <= StWrQ;
          end
        end
        StWrQ: begin
          Addr    <= addr_odd;
          Wdata   <= remainder;
          Wenable <= 1'b1;
          state_q <= StWrR;
        end
        StWrR: begin
          k_q     <= k_q + KOne;
          state_q <= StCheck;
        end
        StDone: begin
          busyvd  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_divider.sv
// Self-checking bench for vector_divider with a behavioural RAM and a
// reference divider built on plain / and % arithmetic.
module tb_vector_divider;

  localparam int RS = 10;
  localparam int W  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [RS-1:0] Addr;
  logic [W-1:0]  Wdata;
  logic [W-1:0]  Rdata;
  logic [RS-1:0] Ndata;
  logic          Wenable;
  logic          startvd;
  logic          busyvd;

  // Bench-side preload port into the RAM model.
  logic          tb_we;
  logic [RS-1:0] tb_addr;
  logic [W-1:0]  tb_wdata;

  logic [W-1:0]  mem [0:(1<<RS)-1];
  int            wen_count = 0;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clock = ~clock;

  vector_divider #(
    .RAM_SIZE (RS),
    .N        (5),
    .NBITS    (W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .Addr    (Addr),
    .Wdata   (Wdata),
    .Rdata   (Rdata),
    .Ndata   (Ndata),
    .Wenable (Wenable),
    .startvd (startvd),
    .busyvd  (busyvd)
  );

  // Synchronous-read RAM, one cycle latency.
  always @(posedge clock) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (Wenable) mem[Addr] <= Wdata;
    Rdata <= mem[Addr];
  end

  always @(posedge clock) if (Wenable === 1'b1) wen_count <= wen_count + 1;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic load_word(input int addr, input logic [W-1:0] data);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = addr[RS-1:0]; tb_wdata = data;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Pulse start for one cycle and follow busyvd until it drops (bounded).
  task automatic run_job(input int n, output int busy_cycles, output bit timed_out);
    @(negedge clock);
    Ndata = n[RS-1:0]; startvd = 1'b1;
    @(negedge clock);
    startvd = 1'b0;
    busy_cycles = 0; timed_out = 1'b0;
    while (busyvd === 1'b1 && !timed_out) begin
      busy_cycles++;
      @(negedge clock);
      if (busy_cycles > 5000) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; startvd = 1'b0; Ndata = '0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    repeat (3) @(negedge clock);
    vectors++; if (busyvd !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busyvd); end
    vectors++; if (Wenable !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b expected 0", Wenable); end
    vectors++; if (Addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h expected 0", Addr); end
    vectors++; if (Wdata !== '0) begin miscompares++; $display("FAIL reset_wdata: got %0h expected 0", Wdata); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Load pairs, run the job over all of them, compare against the model.
  task automatic check_pairs(input string name, input logic [W-1:0] a[$], input logic [W-1:0] b[$]);
    int bc; bit to;
    for (int i = 0; i < a.size(); i++) begin
      load_word(2*i, a[i]);
      load_word(2*i+1, b[i]);
    end
    load_word(2*a.size(), 32'hDEAD_BEEF);
    run_job(a.size(), bc, to);
    vectors++;
    if (to || bc == 0) begin
      miscompares++; $display("FAIL %s_busy: got %0d busy cycles, timeout %0d", name, bc, to);
    end
    for (int i = 0; i < a.size(); i++) begin
      vectors++;
      if (mem[2*i] !== ref_q(a[i], b[i])) begin
        miscompares++;
        $display("FAIL %s_q%0d: got %0h expected %0h", name, i, mem[2*i], ref_q(a[i], b[i]));
      end
      vectors++;
      if (mem[2*i+1] !== ref_r(a[i], b[i])) begin
        miscompares++;
        $display("FAIL %s_r%0d: got %0h expected %0h", name, i, mem[2*i+1], ref_r(a[i], b[i]));
      end
    end
    vectors++;
    if (mem[2*a.size()] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL %s_beyond: got %0h expected deadbeef", name, mem[2*a.size()]);
    end
  endtask

  task automatic test_default_pairs;
    logic [W-1:0] a[$] = '{100, 50, 200};
    logic [W-1:0] b[$] = '{20, 3, 100};
    check_pairs("default", a, b);
  endtask

  task automatic test_div_by_zero;
    logic [W-1:0] a[$] = '{77};
    logic [W-1:0] b[$] = '{0};
    check_pairs("divzero", a, b);
  endtask

  task automatic test_edge_values;
    logic [W-1:0] a[$] = '{32'hFFFF_FFFF, 7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] b[$] = '{1, 9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    check_pairs("edge", a, b);
  endtask

  task automatic test_ndata_zero;
    int bc; bit to; int w0;
    load_word(0, 1234); load_word(1, 7);
    w0 = wen_count;
    run_job(0, bc, to);
    vectors++;
    if (bc != 2 || to) begin miscompares++; $display("FAIL nzero_busy: got %0d cycles expected 2", bc); end
    vectors++;
    if (wen_count != w0) begin miscompares++; $display("FAIL nzero_wen: got %0d writes expected 0", wen_count - w0); end
    vectors++;
    if (mem[0] !== 1234 || mem[1] !== 7) begin
      miscompares++; $display("FAIL nzero_ram: got %0d,%0d expected 1234,7", mem[0], mem[1]);
    end
  endtask

  task automatic test_restart_ignore;
    int cyc; int bc; bit to;
    load_word(0, 100); load_word(1, 20); load_word(2, 900); load_word(3, 30);
    @(negedge clock);
    Ndata = 1; startvd = 1'b1;
    @(negedge clock);
    startvd = 1'b0;
    repeat (5) @(negedge clock);
    Ndata = 2; startvd = 1'b1;
    @(negedge clock);
    startvd = 1'b0;
    cyc = 0;
    while (busyvd === 1'b1 && cyc < 5000) begin cyc++; @(negedge clock); end
    vectors++;
    if (busyvd !== 1'b0) begin miscompares++; $display("FAIL restart_end: busy stuck %b", busyvd); end
    repeat (5) @(negedge clock);
    vectors++;
    if (busyvd !== 1'b0) begin miscompares++; $display("FAIL restart_rearmed: got %b expected 0", busyvd); end
    vectors++;
    if (mem[0] !== 5 || mem[1] !== 0) begin
      miscompares++; $display("FAIL restart_p0: got %0d,%0d expected 5,0", mem[0], mem[1]);
    end
    vectors++;
    if (mem[2] !== 900 || mem[3] !== 30) begin
      miscompares++; $display("FAIL restart_p1: got %0d,%0d expected 900,30", mem[2], mem[3]);
    end
    // Second job on the already-processed pair: 5 / 0 -> all ones, 5.
    run_job(1, bc, to);
    vectors++;
    if (mem[0] !== ref_q(5, 0) || mem[1] !== ref_r(5, 0) || to) begin
      miscompares++; $display("FAIL rerun_p0: got %0h,%0h expected ffffffff,5", mem[0], mem[1]);
    end
    // Reloaded 5/20 -> 0, 5.
    load_word(0, 5); load_word(1, 20);
    run_job(1, bc, to);
    vectors++;
    if (mem[0] !== 0 || mem[1] !== 5 || to) begin
      miscompares++; $display("FAIL reload_p0: got %0d,%0d expected 0,5", mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_mid_job;
    int cyc;
    load_word(0, 100); load_word(1, 20); load_word(2, 50); load_word(3, 3);
    @(negedge clock);
    Ndata = 2; startvd = 1'b1;
    @(negedge clock);
    startvd = 1'b0;
    cyc = 0;
    while (!(Wenable === 1'b1 && Addr == 1) && cyc < 500) begin cyc++; @(negedge clock); end
    vectors++;
    if (cyc >= 500) begin miscompares++; $display("FAIL midreset_wait: pair 0 remainder write not seen"); end
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (busyvd !== 1'b0 || Wenable !== 1'b0) begin
      miscompares++; $display("FAIL midreset_out: got busy %b wen %b expected 0 0", busyvd, Wenable);
    end
    reset = 1'b0;
    repeat (50) @(negedge clock);
    vectors++;
    if (mem[0] !== ref_q(100, 20) || mem[1] !== ref_r(100, 20)) begin
      miscompares++; $display("FAIL midreset_p0: got %0d,%0d expected 5,0", mem[0], mem[1]);
    end
    vectors++;
    if (mem[2] !== 50 || mem[3] !== 3) begin
      miscompares++; $display("FAIL midreset_p1: got %0d,%0d expected 50,3", mem[2], mem[3]);
    end
  endtask

  task automatic test_random;
    for (int round = 0; round < 6; round++) begin
      logic [W-1:0] a[$];
      logic [W-1:0] b[$];
      int n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] av = $urandom;
        logic [W-1:0] bv;
        case ($urandom_range(0, 3))
          0: bv = 0;
          1: bv = $urandom_range(1, 15);
          2: bv = $urandom;
          default: bv = av >> $urandom_range(0, 31);
        endcase
        a.push_back(av);
        b.push_back(bv);
      end
      check_pairs($sformatf("rand%0d", round), a, b);
    end
  endtask

  initial begin
    test_reset();
    test_default_pairs();
    test_div_by_zero();
    test_edge_values();
    test_ndata_zero();
    test_restart_ignore();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_divider.md
Name: vector_divider

Overview:
- Sequential in-place vector divider; it operates on a dual-port word RAM through the RAM's port 2.
- It processes Ndata consecutive (dividend, divisor) pairs stored at word addresses 2k and 2k+1, for k = 0 .. Ndata-1.
- For each pair it overwrites address 2k with the quotient and address 2k+1 with the remainder.
- A start pulse launches the job; busyvd is high for the whole job.

Parameters:
- RAM_SIZE, 10, RAM address width in bits; also the width of Ndata.
- N, 5, width of the divider iteration counter; NBITS must equal 2^N.
- NBITS, 32, data word width: dividend, divisor, quotient and remainder.

Ports:
- clock  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Addr  out  RAM_SIZE  RAM port-2 address.
- Wdata  out  NBITS  RAM port-2 write data.
- Rdata  in  NBITS  RAM port-2 read data.
- Ndata  in  RAM_SIZE  number of pairs to process; sampled when the start pulse is accepted.
- Wenable  out  1  RAM port-2 write enable.
- startvd  in  1  start request; level-sampled, and a one-cycle pulse is sufficient.
- busyvd  out  1  high while a job is in progress.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: busyvd=0, Wenable=0, Addr=0, Wdata=0, pair index=0, state=IDLE.
- Reset mid-job aborts immediately; a RAM write already performed is not undone.
- RAM contract:
  - Synchronous read with 1-cycle latency: Rdata reflects M[Addr as sampled at the previous edge].
  - A write occurs at a rising edge when Wenable=1.
- Address rule: addresses are computed modulo 2^RAM_SIZE.
- Start handling:
  - IDLE: when startvd=1 is sampled, latch Ndata, clear pair index k, set busyvd=1 from the next cycle, and go to CHECK.
  - startvd is ignored while busyvd=1.
- State machine, one state per cycle except DIV:
  - CHECK: if k == latched Ndata, go to DONE; else go to RD_A.
  - RD_A: Addr=2k.
  - RD_B: Addr=2k+1; capture Rdata as dividend.
  - LD_B: capture Rdata as divisor; initialise the divider.
  - DIV: restoring division, one quotient bit per cycle, exactly NBITS cycles; counter is N bits wide.
  - WR_Q: Addr=2k, Wdata=quotient, Wenable=1.
  - WR_R: Addr=2k+1, Wdata=remainder, Wenable=1; then k=k+1 and go to CHECK.
  - DONE: busyvd=0 from the next cycle; return to IDLE.
- Per-pair latency: NBITS+5 cycles. Total job ≈ Ndata·(NBITS+5)+3 cycles.
- Arithmetic: unsigned; quotient = floor(A/B); remainder = A − quotient·B.
- Divide by zero (B=0): quotient = all ones; remainder = A; no error flag.
- Ndata=0: busyvd still goes high for at least 2 cycles (CHECK, DONE) and no RAM write occurs.
- Wenable is high only in WR_Q and WR_R, never in any other state.
- busyvd falls only after the last write has been issued.

Decomposition:
- Shared package: the state enum {IDLE, CHECK, RD_A, RD_B, LD_B, DIV, WR_Q, WR_R, DONE} and the default width constants.
- One natural sub-module: seq_divider, an NBITS-wide serial restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Fixed NBITS-cycle latency.
- The address/FSM controller stays in vector_divider.
- myRAM is an existing external dual-port RAM with the contract above; it is not part of this block.

Test Plan:
- Default pairs: M[0..5] = 100,20, 50,3, 200,100; Ndata=3; reset, then a 1-cycle startvd → busyvd rises, later falls; M[0..5] = 5,0, 16,2, 2,0.
- Divide by zero: M[0]=77, M[1]=0, Ndata=1 → M[0]=0xFFFFFFFF, M[1]=77.
- Edge values: M[0]=0xFFFFFFFF, M[1]=1 → quotient 0xFFFFFFFF, remainder 0; and 7/9 → quotient 0, remainder 7.
- Ndata=0 → busyvd high for 2 cycles, Wenable never asserted, RAM unchanged.
- Restart/ignore: a second startvd during busy is ignored; a new start after completion with Ndata=1 processes pair 0 again (5/20 → 0, 5 after reloading 100/20 → 5, 0).
- Reset mid-job: assert reset during the DIV of pair 1 → busyvd=0 and Wenable=0 in the following cycle; pair 0 results remain; pair 1 unmodified.
